tmp2_scheduler: RTL
===================

Name: tmp2_scheduler

Overview:
Sequencer that sits between user logic and the tmp2 Pmod TMP2 interface. It holds pending requests: software reset, threshold-register writes, one-shot conversions and periodic ambient-temperature polls. It issues them one at a time to tmp2 using a level-request / busy handshake. It also latches each completed temperature reading and flags stalled transactions.

Parameters:
POLL_CYCLES, 100000000, clk cycles between automatic update requests (1 s at 100 MHz); minimum 2
GAP_CYCLES, 256, consecutive cycles of t_busy low that mark a command complete; must exceed 2 clkI2Cx2 periods in clk cycles
TIMEOUT_CYCLES, 1048576, maximum cycles spent in WAIT_ACCEPT or WAIT_DONE before abort

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
enable  in  1  enables periodic polling; does not gate host requests
host_sw_rst  in  1  pulse: request device software reset
host_one_shot  in  1  pulse: request one-shot conversion
host_wr_valid  in  1  threshold write request, accepted when host_wr_ready
host_wr_target  in  2  0=HYST, 1=CRIT, 2=LOW, 3=HIGH
host_wr_data  in  16  threshold value; HYST uses [7:0]
host_wr_ready  out  1  ~pending[host_wr_target]
host_clr_err  in  1  clears timeout_o
t_busy  in  1  tmp2 busy
t_valid  in  1  tmp2 valid_o
t_temperature  in  16  tmp2 temperature_o
t_sw_rst, t_update, t_one_shot, t_write_temperature  out  1 each  tmp2 control inputs
t_write_temp_target  out  2  tmp2 write target
t_temperature_i  out  16  tmp2 write data
temp_o  out  16  last valid reading
temp_valid  out  1  one-cycle pulse when temp_o updates
timeout_o  out  1  sticky: a transaction timed out
sched_busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: all outputs 0. All pending flags 0. Poll counter 0. FSM in IDLE.
- Pending flags: rst_p, one_p, poll_p, and wr_p[3:0], each with a 16-bit value register.
  - host_wr_valid & host_wr_ready: sets wr_p[target] and stores data.
  - host_wr_valid while not ready: ignored, data unchanged.
  - A flag set on the same cycle as its own clear takes the set.
- Poll counter: counts while enable=1. At POLL_CYCLES-1 it wraps to 0 and sets poll_p.
  - enable=0 holds the count; poll_p is unchanged.
- Arbitration in IDLE, fixed priority: rst_p > wr_p (lowest index first) > one_p > poll_p.
  - The chosen flag is cleared on entry to ISSUE.
  - Write commands register the selected target and data on that edge.
- FSM states:
  - IDLE: any flag pending -> ISSUE.
  - ISSUE: drive exactly one t_* request high, plus target/data for writes; -> WAIT_ACCEPT next cycle.
  - WAIT_ACCEPT: request held high until t_busy=1, then request drops the same cycle -> WAIT_DONE.
  - WAIT_DONE: gap counter counts consecutive t_busy=0 cycles and resets on t_busy=1. At GAP_CYCLES -> COMPLETE.
  - COMPLETE (1 cycle): if the command was update and t_valid=1, then temp_o<=t_temperature and temp_valid=1. -> IDLE.
- Write commands: tmp2 runs a register write followed by a pointer write with a short busy-low gap between them. The gap filter treats both as one command.
- Only one request output is ever high; t_write_temp_target and t_temperature_i stay stable from ISSUE until COMPLETE.
- Timeout: a cycle counter clears on entering WAIT_ACCEPT and WAIT_DONE. Reaching TIMEOUT_CYCLES sets timeout_o, drops all requests and returns to IDLE.
  - The aborted command's flag is not re-set.
  - host_clr_err clears timeout_o; a simultaneous new timeout wins.
- Update completion with t_valid=0: temp_o is unchanged and there is no pulse.
- Duplicate host pulses while a flag is pending merge into that one flag.
- rst mid-transaction: immediate return to IDLE with all requests low.

Optional Feature:
TMP2_SCHED_ALARM_EN
- Defined:
  - Adds output alarm_o [1:0] and two shadow registers updated by accepted LOW/HIGH writes.
  - On each temp_valid, as a signed 16-bit comparison: alarm_o[1] <= temp > shadow_high; alarm_o[0] <= temp < shadow_low.
  - Reset: shadows 0, alarm_o 0.
- Undefined: no alarm_o port and no shadow registers.

Test Plan:
- POLL_CYCLES=1000, enable=1, tmp2 model returns 16'h0C80 -> t_update held until busy; after busy-low gap, temp_o=16'h0C80 with one temp_valid pulse; repeats every ~1000 cycles.
- host_wr_valid target=3 data=16'h1E00 and target=2 data=16'h0A00 in the same cycle window -> LOW (2) issued before HIGH (3); host_wr_ready low for each until its issue; t_temperature_i matches.
- host_sw_rst, host_one_shot and a poll all pending in the same cycle -> issue order sw_rst, one_shot, update.
- Model never raises busy, TIMEOUT_CYCLES=64 -> request dropped after 64 cycles, timeout_o=1 until host_clr_err.
- rst asserted during WAIT_DONE -> all outputs 0 immediately; no temp_valid afterwards.
- (ALARM_EN) HIGH shadow=16'h1E00, reading 16'h2000 -> alarm_o=2'b10; reading 16'hF000 with LOW shadow=16'h0000 -> alarm_o=2'b01.

Source files
------------

// File: rtl/tmp2_scheduler.sv
// tmp2_scheduler: holds pending software-reset, threshold-write, one-shot and
// periodic update requests and issues them one at a time to the tmp2
// controller over a level-request / busy handshake. It latches each completed
// temperature reading and flags transactions that stall.
// Optional build macro TMP2_SCHED_ALARM_EN adds alarm_o driven by LOW/HIGH
// threshold shadows.
module tmp2_scheduler #(
  parameter int unsigned POLL_CYCLES    = 100_000_000,
  parameter int unsigned GAP_CYCLES     = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1_048_576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        host_sw_rst,
  input  logic        host_one_shot,
  input  logic        host_wr_valid,
  input  logic [1:0]  host_wr_target,
  input  logic [15:0] host_wr_data,
  output logic        host_wr_ready,
  input  logic        host_clr_err,
  input  logic        t_busy,
  input  logic        t_valid,
  input  logic [15:0] t_temperature,
  output logic        t_sw_rst,
  output logic        t_update,
  output logic        t_one_shot,
  output logic        t_write_temperature,
  output logic [1:0]  t_write_temp_target,
  output logic [15:0] t_temperature_i,
  output logic [15:0] temp_o,
  output logic        temp_valid,
  output logic        timeout_o,
`ifdef TMP2_SCHED_ALARM_EN
  output logic [1:0]  alarm_o,
`endif
  output logic        sched_busy
);

  localparam int POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACCEPT, S_WAIT_DONE, S_COMPLETE
  } state_t;

  typedef enum logic [1:0] {CMD_RST, CMD_WR, CMD_ONE, CMD_UPD} cmd_t;

  state_t            state, state_d;
  cmd_t              cmd_q, pick_cmd;
  logic              rst_p, one_p, poll_p;
  logic [3:0]        wr_p;
  logic [15:0]       wr_val [4];
  logic [POLL_W-1:0] poll_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              pick_valid, take, wr_accept, poll_wrap;
  logic [1:0]        pick_tgt;
  logic              timeout_hit, req_on, got_reading;

  assign wr_accept     = host_wr_valid & ~wr_p[host_wr_target];
  assign host_wr_ready = ~rst & ~wr_p[host_wr_target];
  assign poll_wrap     = enable && (poll_cnt == POLL_LAST);
  assign take          = (state == S_IDLE) && pick_valid;
  assign sched_busy    = (state != S_IDLE);
  assign got_reading   = (state == S_COMPLETE) && (cmd_q == CMD_UPD) && t_valid;

  // Request is raised in ISSUE and held until tmp2 reports busy; it drops
  // combinationally so tmp2 never sees it after starting the command.
  assign req_on              = (state == S_ISSUE) || ((state == S_WAIT_ACCEPT) && !t_busy);
  assign t_sw_rst            = req_on && (cmd_q == CMD_RST);
  assign t_write_temperature = req_on && (cmd_q == CMD_WR);
  assign t_one_shot          = req_on && (cmd_q == CMD_ONE);
  assign t_update            = req_on && (cmd_q == CMD_UPD);

  // Fixed-priority pick: sw reset, writes (lowest target first), one-shot, poll.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pick_valid = rst_p | (|wr_p) | one_p | poll_p;
    pick_cmd   = CMD_UPD;
    pick_tgt   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (wr_p[i]) pick_tgt = 2'(i);
    end
    if (rst_p)        pick_cmd = CMD_RST;
    else if (|wr_p)   pick_cmd = CMD_WR;
    else if (one_p)   pick_cmd = CMD_ONE;
  end

  // Pending flags: the picked flag clears on entry to ISSUE; a set on the
  // same edge is written later in the block and therefore wins.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order across blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_p  <= 1'b0;
      one_p  <= 1'b0;
      poll_p <= 1'b0;
      wr_p   <= '0;
    end else begin
      if (take) begin
        unique case (pick_cmd)
          CMD_RST: rst_p          <= 1'b0;
          CMD_WR:  wr_p[pick_tgt] <= 1'b0;
          CMD_ONE: one_p          <= 1'b0;
          default: poll_p         <= 1'b0;
        endcase
      end
      if (host_sw_rst)   rst_p                <= 1'b1;
      if (host_one_shot) one_p                <= 1'b1;
      if (poll_wrap)     poll_p               <= 1'b1;
      if (wr_accept)     wr_p[host_wr_target] <= 1'b1;
    end
  end

  // Write data holding registers, loaded when a write is accepted.
  // NOTE: no reset on this storage; a slot is only read while its pending
  // flag is set, and that flag is reset.
  always_ff @(posedge clk) begin
    if (wr_accept) wr_val[host_wr_target] <= host_wr_data;
  end

  // Poll timer: free-runs while enabled, holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            poll_cnt <= '0;
    else if (poll_wrap) poll_cnt <= '0;
    else if (enable)    poll_cnt <= poll_cnt + 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // FSM next state: gap filter ends a command, timeout aborts it.
  always_comb begin
    state_d     = state;
    timeout_hit = 1'b0;
    unique case (state)
      S_IDLE:        if (pick_valid) state_d = S_ISSUE;
      S_ISSUE:       state_d = S_WAIT_ACCEPT;
      S_WAIT_ACCEPT: begin
        if (t_busy) begin
          state_d = S_WAIT_DONE;
        end else if (to_cnt == TO_LAST) begin
          timeout_hit = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!t_busy && (gap_cnt == GAP_LAST)) begin
          state_d = S_COMPLETE;
        end else if (to_cnt == TO_LAST) begin
          timeout_hit = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_COMPLETE:    state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  // Timeout and busy-low gap counters, cleared on entry to each wait state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt  <= '0;
      gap_cnt <= '0;
    end else begin
      unique case (state)
        S_ISSUE: to_cnt <= '0;
        S_WAIT_ACCEPT: begin
          if (t_busy) begin
            to_cnt  <= '0;
            gap_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          to_cnt  <= to_cnt + 1'b1;
          gap_cnt <= t_busy ? '0 : gap_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Command, write target and write data captured on entry to ISSUE and held
  // until the next command is picked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q               <= CMD_RST;
      t_write_temp_target <= 2'd0;
      t_temperature_i     <= 16'd0;
    end else if (take) begin
      cmd_q <= pick_cmd;
      if (pick_cmd == CMD_WR) begin
        t_write_temp_target <= pick_tgt;
        t_temperature_i     <= wr_val[pick_tgt];
      end
    end
  end

  // Latch completed update readings and pulse temp_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      temp_o     <= 16'd0;
      temp_valid <= 1'b0;
    end else begin
      temp_valid <= got_reading;
      if (got_reading) temp_o <= t_temperature;
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               timeout_o <= 1'b0;
    else if (timeout_hit)  timeout_o <= 1'b1;
    else if (host_clr_err) timeout_o <= 1'b0;
  end

`ifdef TMP2_SCHED_ALARM_EN
  logic [15:0] shadow_low, shadow_high;

  // Threshold shadows follow accepted writes; alarms re-evaluate per reading.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_low  <= 16'd0;
      shadow_high <= 16'd0;
      alarm_o     <= 2'b00;
    end else begin
      if (wr_accept && (host_wr_target == 2'd2)) shadow_low  <= host_wr_data;
      if (wr_accept && (host_wr_target == 2'd3)) shadow_high <= host_wr_data;
      if (got_reading) begin
        alarm_o[1] <= $signed(t_temperature) > $signed(shadow_high);
        alarm_o[0] <= $signed(t_temperature) < $signed(shadow_low);
      end
    end
  end
`endif

endmodule
